// File: rtl/alu_div_if.sv
// Start/done handshake bundle between execute-stage control and the sequential divider.
interface alu_div_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sign;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             Ofl;
  logic             Z;
  logic             dz;

  modport master (
    output start, sign, A, B,
    input  busy, done, Q, R, Ofl, Z, dz
  );

  modport slave (
    input  start, sign, A, B,
    output busy, done, Q, R, Ofl, Z, dz
  );
endinterface

// File: rtl/alu_div_seq.sv
// Iterative restoring divider, signed/unsigned, start/done handshake, 18-cycle latency.
// Optional ALU_DIV_EARLY_EXIT_EN: finish in one cycle when |A| < |B|.
module alu_div_seq #(
  parameter int WIDTH = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_div_if.slave  div_if
);
  localparam int               CW      = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_e;

  state_e           state_q, state_d;
  logic             sign_q, sign_d;
  logic             a_neg_q, a_neg_d;
  logic             b_neg_q, b_neg_d;
  logic             ofl_pend_q, ofl_pend_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             ofl_q, ofl_d;
  logic             z_q, z_d;
  logic             dz_q, dz_d;

  logic             a_neg_in, b_neg_in;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, trial;

  assign a_neg_in = div_if.sign & div_if.A[WIDTH-1];
  assign b_neg_in = div_if.sign & div_if.B[WIDTH-1];
  assign a_mag    = a_neg_in ? (~div_if.A + ONE) : div_if.A;
  assign b_mag    = b_neg_in ? (~div_if.B + ONE) : div_if.B;

  // Partial remainder is kept below the divisor, so the extra top bit only matters during the trial.
  assign shifted  = {rem_q, dvd_q[WIDTH-1]};
  assign trial    = shifted - {1'b0, div_q};

  always_comb begin
    // NOTE: every next-state value defaults to its current value first, so no path infers a latch.
    state_d    = state_q;
    sign_d     = sign_q;
    a_neg_d    = a_neg_q;
    b_neg_d    = b_neg_q;
    ofl_pend_d = ofl_pend_q;
    rem_d      = rem_q;
    dvd_d      = dvd_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    q_d        = q_q;
    r_d        = r_q;
    ofl_d      = ofl_q;
    z_d        = z_q;
    dz_d       = dz_q;

    unique case (state_q)
      S_IDLE: begin
        if (div_if.start) begin
          sign_d     = div_if.sign;
          a_neg_d    = a_neg_in;
          b_neg_d    = b_neg_in;
          dvd_d      = a_mag;
          div_d      = b_mag;
          rem_d      = '0;
          cnt_d      = '0;
          ofl_pend_d = div_if.sign && (div_if.A == MIN_NEG) && (div_if.B == '1);
          if (div_if.B == '0) begin
            state_d = S_DONE;
            q_d     = '1;
            r_d     = div_if.A;
            z_d     = 1'b0;
            ofl_d   = 1'b0;
            dz_d    = 1'b1;
          end
`ifdef ALU_DIV_EARLY_EXIT_EN
          else if (a_mag < b_mag) begin
            state_d = S_DONE;
            q_d     = '0;
            r_d     = div_if.A;
            z_d     = 1'b1;
            ofl_d   = 1'b0;
            dz_d    = 1'b0;
          end
`endif
          else begin
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        dvd_d = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_d == LAST) state_d = S_FIXUP;
      end

      S_FIXUP: begin
        // min_neg / -1 needs no special data path: |A|/|B| = min_neg with equal signs.
        q_d     = (sign_q && (a_neg_q ^ b_neg_q)) ? (~dvd_q + ONE) : dvd_q;
        r_d     = a_neg_q ? (~rem_q + ONE) : rem_q;
        z_d     = (q_d == '0);
        ofl_d   = ofl_pend_q;
        dz_d    = 1'b0;
        state_d = S_DONE;
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sign_q     <= 1'b0;
      a_neg_q    <= 1'b0;
      b_neg_q    <= 1'b0;
      ofl_pend_q <= 1'b0;
      rem_q      <= '0;
      dvd_q      <= '0;
      div_q      <= '0;
      cnt_q      <= '0;
      q_q        <= '0;
      r_q        <= '0;
      ofl_q      <= 1'b0;
      z_q        <= 1'b1;
      dz_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      sign_q     <= sign_d;
      a_neg_q    <= a_neg_d;
      b_neg_q    <= b_neg_d;
      ofl_pend_q <= ofl_pend_d;
      rem_q      <= rem_d;
      dvd_q      <= dvd_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      q_q        <= q_d;
      r_q        <= r_d;
      ofl_q      <= ofl_d;
      z_q        <= z_d;
      dz_q       <= dz_d;
    end
  end

  assign div_if.busy = (state_q == S_CALC) || (state_q == S_FIXUP);
  assign div_if.done = (state_q == S_DONE);
  assign div_if.Q    = q_q;
  assign div_if.R    = r_q;
  assign div_if.Ofl  = ofl_q;
  assign div_if.Z    = z_q;
  assign div_if.dz   = dz_q;
endmodule

// File: tb/tb_alu_div_seq.sv
// Scoreboard bench for alu_div_seq: expected results from an arithmetic model, checked on done.
module tb_alu_div_seq;
  localparam int W = 16;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         ofl;
    logic         z;
    logic         dz;
    int           e0;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [W-1:0] prev_q = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  alu_div_if #(.WIDTH(W)) dif ();
  alu_div_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .div_if(dif));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference: plain integer division, which truncates toward zero with remainder taking the dividend's sign.
  function automatic exp_t model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int sa, sbv, ma, mb;
    sa  = $signed(a);
    sbv = $signed(b);
    ma  = s ? ((sa < 0) ? -sa : sa) : int'(a);
    mb  = s ? ((sbv < 0) ? -sbv : sbv) : int'(b);
    e.ofl = 1'b0; e.dz = 1'b0; e.lat = 18; e.e0 = 0;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dz = 1'b1; e.lat = 1;
    end else if (s && a == 16'h8000 && b == 16'hFFFF) begin
      e.q = 16'h8000; e.r = '0; e.ofl = 1'b1;
    end else if (s) begin
      e.q = 16'(sa / sbv); e.r = 16'(sa % sbv);
    end else begin
      e.q = a / b; e.r = a % b;
    end
`ifdef ALU_DIV_EARLY_EXIT_EN
    if (b != '0 && ma < mb) e.lat = 1;
`endif
    e.z = (e.q == '0);
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && dif.done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", {31'b0, dif.done}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("Q",   {16'b0, dif.Q}, {16'b0, mon_e.q});
        check("R",   {16'b0, dif.R}, {16'b0, mon_e.r});
        check("Ofl", {31'b0, dif.Ofl}, {31'b0, mon_e.ofl});
        check("Z",   {31'b0, dif.Z}, {31'b0, mon_e.z});
        check("dz",  {31'b0, dif.dz}, {31'b0, mon_e.dz});
        check("latency", cyc - mon_e.e0 + 1, mon_e.lat);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((dif.busy || dif.done || sb.size() != 0) && n < 100);
    check("idle_reached", {31'b0, n < 100}, 32'd1);
  endtask

  task automatic start_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    exp_t e;
    wait_idle();
    e = model(s, a, b);
    e.e0 = cyc + 1;
    if (push) sb.push_back(e);
    dif.start = 1'b1; dif.sign = s; dif.A = a; dif.B = b;
    @(negedge clk);
    dif.start = 1'b0;
    dif.sign  = 1'($urandom);
    dif.A     = W'($urandom);
    dif.B     = W'($urandom);
    if (e.lat == 18) begin
      check("busy_after_start", {31'b0, dif.busy}, 32'd1);
      check("q_hold", {16'b0, dif.Q}, {16'b0, prev_q});
    end
    if (push) prev_q = e.q;
  endtask

  initial begin
    int n;
    dif.start = 1'b0; dif.sign = 1'b0; dif.A = '0; dif.B = '0;
    #12;
    check("rst_busy", {31'b0, dif.busy}, 32'd0);
    check("rst_done", {31'b0, dif.done}, 32'd0);
    check("rst_Q",    {16'b0, dif.Q}, 32'd0);
    check("rst_R",    {16'b0, dif.R}, 32'd0);
    check("rst_Z",    {31'b0, dif.Z}, 32'd1);
    check("rst_Ofl",  {31'b0, dif.Ofl}, 32'd0);
    check("rst_dz",   {31'b0, dif.dz}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    start_op(1'b0, 16'h0064, 16'h0007, 1'b1);
    start_op(1'b1, 16'hFF9C, 16'h0007, 1'b1);
    start_op(1'b1, 16'h0064, 16'hFFF9, 1'b1);
    start_op(1'b1, 16'h8000, 16'hFFFF, 1'b1);
    start_op(1'b0, 16'h8000, 16'hFFFF, 1'b1);
    start_op(1'b0, 16'h1234, 16'h0000, 1'b1);
    start_op(1'b0, 16'h0010, 16'h0004, 1'b1);
    start_op(1'b0, 16'h0003, 16'h0009, 1'b1);
    start_op(1'b1, 16'hFFFD, 16'h0009, 1'b1);
    start_op(1'b1, 16'h0000, 16'h0005, 1'b1);
    start_op(1'b0, 16'hFFFF, 16'h0001, 1'b1);
    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] rb;
      rb = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      start_op(1'($urandom), W'($urandom), rb, 1'b1);
    end

    // A second start while busy must not queue or disturb the running operation.
    start_op(1'b0, 16'h1234, 16'h0011, 1'b1);
    repeat (3) @(negedge clk);
    dif.start = 1'b1; dif.A = 16'h0001; dif.B = 16'h0001;
    @(negedge clk);
    dif.start = 1'b0;

    // Start asserted during the done cycle is dropped.
    start_op(1'b1, 16'hFF00, 16'h0013, 1'b1);
    n = 0;
    while (!dif.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", {31'b0, dif.done}, 32'd1);
    dif.start = 1'b1; dif.sign = 1'b0; dif.A = 16'h0005; dif.B = 16'h0001;
    @(negedge clk);
    dif.start = 1'b0;
    check("restart_in_done_ignored", {31'b0, dif.busy | dif.done}, 32'd0);
    repeat (25) @(negedge clk);

    // Reset in the middle of an operation aborts it with no done pulse.
    start_op(1'b0, 16'hABCD, 16'h0003, 1'b0);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", {31'b0, dif.busy}, 32'd0);
    check("abort_done", {31'b0, dif.done}, 32'd0);
    check("abort_Q",    {16'b0, dif.Q}, 32'd0);
    check("abort_R",    {16'b0, dif.R}, 32'd0);
    check("abort_Z",    {31'b0, dif.Z}, 32'd1);
    prev_q = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);

    start_op(1'b1, 16'h7FFF, 16'hFFFE, 1'b1);
    wait_idle();
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
